opsel_stage: RTL

Parametrised, registered operand-select stage for the 5-stage CPU datapath. It takes NUM_SRC candidate operands, such as register file, EX/MEM forward, MEM/WB forward, immediate and PC, and picks one by a fixed priority over per-source hit bits. The choice is captured in a one-deep pipeline register behind a valid/ready handshake, with stall, flush and optional per-source selection statistics. It replaces the ad-hoc combinational forwarding muxes and their undefined "no match" case.

---
 rtl/opsel_pkg.sv | 23 ++
 rtl/prio_enc.sv | 28 ++
 rtl/opsel_stage.sv | 92 +++++++++
 3 files changed

// File: rtl/opsel_pkg.sv
// Shared constants and helpers for the operand-select stage and its priority encoder.
package opsel_pkg;

   localparam int DEF_WIDTH   = 16;
   localparam int DEF_NUM_SRC = 5;

   // Upper bounds for the generic flat-bus slice helper
   localparam int MAX_W   = 64;
   localparam int MAX_SRC = 16;

   typedef logic [$clog2(DEF_NUM_SRC)-1:0] sel_idx_t;

   // Return field idx of width w from a flat bus (zero-extended to the helper bounds)
   function automatic logic [MAX_W-1:0] bus_slice(input logic [MAX_SRC*MAX_W-1:0] bus,
                                                  input int idx, input int w);
      logic [MAX_SRC*MAX_W-1:0] sh;
      logic [MAX_W-1:0]         r;
      sh = bus >> (idx * w);
      for (int b = 0; b < MAX_W; b++) r[b] = (b < w) ? sh[b] : 1'b0;
      return r;
   endfunction

endpackage

// File: rtl/prio_enc.sv
// Highest-index-wins priority encoder with a fixed default index when nothing hits.
module prio_enc #(
   parameter  int N       = 5,
   parameter  int DEFAULT = 0,
   localparam int IW      = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  hit,
   output logic [IW-1:0] idx,
   output logic          any_hit,
   output logic          multi
);

   int cnt;

   always_comb begin
      idx = IW'(DEFAULT);
      cnt = 0;
      for (int i = 0; i < N; i++) begin
         if (hit[i]) begin
            idx = IW'(i);
            cnt = cnt + 1;
         end
      end
      any_hit = |hit;
      multi   = (cnt > 1);
   end

endmodule

// File: rtl/opsel_stage.sv
// Registered operand-select stage: priority pick over NUM_SRC candidates behind valid/ready.
// Optional per-source selection counters are built when OPSEL_STATS_EN is defined.
module opsel_stage
   import opsel_pkg::*;
#(
   parameter int WIDTH       = DEF_WIDTH,
   parameter int NUM_SRC     = DEF_NUM_SRC,
   parameter int DEFAULT_SRC = 0,
   parameter int CNT_W       = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [NUM_SRC*WIDTH-1:0]   src_data,
   input  logic [NUM_SRC-1:0]         src_hit,
   input  logic                       flush,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_data,
   output logic [$clog2(NUM_SRC)-1:0] out_sel,
   output logic                       out_multi,
   input  logic                       cnt_clr,
   output logic [NUM_SRC*CNT_W-1:0]   sel_cnt
);

   localparam int SEL_W = $clog2(NUM_SRC);

   logic [SEL_W-1:0]             win;
   logic [SEL_W-1:0]             win_sel;
   logic                         any_hit;
   logic                         multi;
   logic                         xfer;
   logic [WIDTH-1:0]             sel_data;
   logic [MAX_SRC*MAX_W-1:0]     bus_ext;

   prio_enc #(.N(NUM_SRC), .DEFAULT(DEFAULT_SRC)) u_enc (
      .hit     (src_hit),
      .idx     (win),
      .any_hit (any_hit),
      .multi   (multi)
   );

   assign win_sel  = any_hit ? win : SEL_W'(DEFAULT_SRC);
   assign bus_ext  = {{(MAX_SRC*MAX_W-NUM_SRC*WIDTH){1'b0}}, src_data};
   assign sel_data = WIDTH'(bus_slice(bus_ext, int'(win_sel), WIDTH));

   assign in_ready = !out_valid || out_ready;
   assign xfer     = in_valid && in_ready;

   // Flush drops the held entry and any beat offered in the same cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= SEL_W'(DEFAULT_SRC);
         out_multi <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (xfer) begin
         out_valid <= 1'b1;
         out_data  <= sel_data;
         out_sel   <= win_sel;
         out_multi <= multi;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef OPSEL_STATS_EN
   for (genvar i = 0; i < NUM_SRC; i++) begin : g_cnt
      logic [CNT_W-1:0] cnt_q;

      // Clear beats a same-cycle increment; count saturates at all-ones
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)
            cnt_q <= '0;
         else if (cnt_clr)
            cnt_q <= '0;
         else if (xfer && !flush && (win_sel == SEL_W'(i)) && (cnt_q != '1))
            cnt_q <= cnt_q + CNT_W'(1);
      end

      assign sel_cnt[i*CNT_W +: CNT_W] = cnt_q;
   end
`else
   logic unused_cnt_clr;
   assign unused_cnt_clr = cnt_clr;
   assign sel_cnt        = '0;
`endif

endmodule
